// File: rtl/n2one_merge_pkg.sv
// Shared helpers for the n2one_merge slice.
//   wrap_add : modular pointer increment for circular buffers whose depth need not be a power
//              of two. The caller guarantees base < depth and ofs <= depth.
package n2one_merge_pkg;

  function automatic int unsigned wrap_add(input int unsigned base, input int unsigned ofs,
                                           input int unsigned depth);
    int unsigned sum;
    sum = base + ofs;
    return (sum >= depth) ? (sum - depth) : sum;
  endfunction

endpackage

// File: rtl/n2one_merge_lane_compact.sv
// Lane compactor: packs the valid lanes of an NCH-wide issue group into the low slots of the
// output, in ascending lane order, and reports how many lanes were valid. Purely combinational.
// Ports:
//   i_vdin  per-lane valid
//   i_din   lane i at bits [i*WIDTH +: WIDTH]
//   o_data  packed entries, slot j at bits [j*WIDTH +: WIDTH]; unused slots are zero
//   o_cnt   number of valid lanes (0..NCH)
module n2one_merge_lane_compact #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNTW  = $clog2(NCH + 1)
) (
  input  logic [NCH-1:0]       i_vdin,
  input  logic [NCH*WIDTH-1:0] i_din,
  output logic [NCH*WIDTH-1:0] o_data,
  output logic [CNTW-1:0]      o_cnt
);

  // Exclusive prefix count: w_pos[i] is the slot lane i lands in when it is valid.
  logic [CNTW-1:0] w_pos [NCH];

  always_comb begin
    logic [CNTW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NCH; i++) begin
      w_pos[i] = acc;
      acc      = acc + CNTW'(i_vdin[i]);
    end
    o_cnt = acc;
  end

  // A lane can only move down, so slot j draws from lanes j..NCH-1.
  always_comb begin
    o_data = '0;
    for (int j = 0; j < NCH; j++) begin
      for (int i = j; i < NCH; i++) begin
        if (i_vdin[i] && (w_pos[i] == CNTW'(j))) begin
          o_data[j*WIDTH +: WIDTH] = i_din[i*WIDTH +: WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/n2one_merge.sv
// N-to-one merge: turns NCH parallel valid/data lanes into a single in-order stream of one
// entry per cycle. The logical stream is the buffer contents (oldest first) followed by this
// cycle's compacted lanes; the head leaves combinationally, the rest is buffered.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   pause       downstream hold: no dequeue, inputs ignored
//   vdin, din   per-lane valid and data (lane i at [i*WIDTH +: WIDTH], lane 0 oldest)
//   dout, vdout merged output (dout is zero when vdout=0)
//   pnc         upstream must present no valid lanes next cycle
//   occ         registered buffer occupancy
//   ovf         sticky overflow flag, cleared only by reset
module n2one_merge
  import n2one_merge_pkg::*;
#(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned NCH   = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pause,
  input  logic [NCH-1:0]               vdin,
  input  logic [NCH*WIDTH-1:0]         din,
  output logic [WIDTH-1:0]             dout,
  output logic                         vdout,
  output logic                         pnc,
  output logic [$clog2(DEPTH+1)-1:0]   occ,
  output logic                         ovf
);

  localparam int unsigned OCCW      = $clog2(DEPTH + 1);
  localparam int unsigned PTRW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW      = $clog2(NCH + 1);
  // Worst legal next cycle adds NCH-1 entries; staying at or below this keeps occ <= DEPTH.
  localparam int unsigned PncThresh = DEPTH - NCH + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]  r_rptr;
  logic [PTRW-1:0]  r_wptr;
  logic [OCCW-1:0]  r_occ;
  logic             r_ovf;

  logic [NCH*WIDTH-1:0] w_pack;
  logic [CNTW-1:0]      w_k;

  // One write port per packed slot; slot s goes to (wptr + s - skip) mod DEPTH.
  logic [NCH-1:0]   w_wr_en;
  logic [PTRW-1:0]  w_wr_addr [NCH];
  logic [WIDTH-1:0] w_wr_data [NCH];

  logic [OCCW-1:0]  w_occ_next;
  logic [PTRW-1:0]  w_rptr_next;
  logic [PTRW-1:0]  w_wptr_next;
  logic             w_ovf_set;

  n2one_merge_lane_compact #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .CNTW  (CNTW)
  ) u_lane_compact (
    .i_vdin (vdin),
    .i_din  (din),
    .o_data (w_pack),
    .o_cnt  (w_k)
  );

  always_comb begin
    int unsigned occ_i;
    int unsigned k_i;
    int unsigned wptr_i;
    int unsigned rptr_i;
    int unsigned total;
    int unsigned after_deq;
    int unsigned skip;
    int unsigned kept;
    int unsigned n_wr;

    occ_i     = 32'(r_occ);
    k_i       = 32'(w_k);
    wptr_i    = 32'(r_wptr);
    rptr_i    = 32'(r_rptr);
    total     = occ_i + k_i;
    // Entries left in the buffer once the head has gone (head from buffer only if non-empty).
    after_deq = (occ_i != 0) ? (occ_i - 1) : 0;
    // With an empty buffer the head is slot 0 of the packed lanes, so it is not written.
    skip      = (occ_i == 0) ? 1 : 0;
    kept      = 0;
    n_wr      = 0;

    vdout       = 1'b0;
    dout        = '0;
    w_wr_en     = '0;
    w_ovf_set   = 1'b0;
    w_occ_next  = r_occ;
    w_rptr_next = r_rptr;
    w_wptr_next = r_wptr;
    pnc         = (r_occ != '0);
    for (int unsigned s = 0; s < NCH; s++) begin
      w_wr_addr[s] = '0;
      w_wr_data[s] = '0;
    end

    if (!pause) begin
      kept       = (total == 0) ? 0 : (((total - 1) > DEPTH) ? DEPTH : (total - 1));
      w_ovf_set  = (total > (DEPTH + 1));
      w_occ_next = OCCW'(kept);
      pnc        = (kept > PncThresh);

      if (total != 0) begin
        vdout = 1'b1;
        dout  = (occ_i != 0) ? r_mem[r_rptr] : w_pack[WIDTH-1:0];

        // Youngest slots past the DEPTH limit simply get no write enable.
        for (int unsigned s = 0; s < NCH; s++) begin
          if ((s >= skip) && (s < k_i) && ((after_deq + (s - skip)) < DEPTH)) begin
            w_wr_en[s]   = 1'b1;
            w_wr_addr[s] = PTRW'(wrap_add(wptr_i, s - skip, DEPTH));
            w_wr_data[s] = w_pack[s*WIDTH +: WIDTH];
            n_wr         = n_wr + 1;
          end
        end

        if (occ_i != 0) begin
          w_rptr_next = PTRW'(wrap_add(rptr_i, 1, DEPTH));
        end
        w_wptr_next = PTRW'(wrap_add(wptr_i, n_wr, DEPTH));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_occ  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_rptr <= w_rptr_next;
      r_wptr <= w_wptr_next;
      r_occ  <= w_occ_next;
      r_ovf  <= r_ovf | w_ovf_set;
    end
  end

  // Storage is not reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < NCH; s++) begin
      if (w_wr_en[s]) begin
        r_mem[w_wr_addr[s]] <= w_wr_data[s];
      end
    end
  end

  assign occ = r_occ;
  assign ovf = r_ovf;

endmodule
